csr_mvm_engine: RTL and testbench

CSR_MVM_ENGINE -- requirements
Module: csr_mvm_engine

---
 rtl/csr_mvm_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_csr_mvm_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_mvm_engine.sv
// Sparse (CSR-style) matrix times binary spike-vector engine.
// Entries are streamed in, one is applied per cycle, and rows are drained in order.
module csr_mvm_engine #(
  parameter  int ROWS    = 4,
  parameter  int COLS    = 4,
  parameter  int NNZ_MAX = 16,
  parameter  int VAL_W   = 8,
  parameter  int ACC_W   = 12,
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             keep_matrix,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RW-1:0]    in_row,
  input  logic [CW-1:0]    in_col,
  input  logic [VAL_W-1:0] in_val,
  input  logic             in_last,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [COLS-1:0]  vec_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [RW-1:0]    out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  localparam int IW = (NNZ_MAX > 1) ? $clog2(NNZ_MAX) : 1;
  localparam int NW = $clog2(NNZ_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_VEC,
    S_COMPUTE,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NW-1:0]    r_nnz;
  logic [NW-1:0]    r_k;
  logic [RW-1:0]    r_r;
  logic [COLS-1:0]  r_vec;
  logic             r_err;
  logic             r_mvalid;
  logic [ACC_W-1:0] r_acc [ROWS];

  logic [RW-1:0]    r_row [NNZ_MAX];
  logic [CW-1:0]    r_col [NNZ_MAX];
  logic [VAL_W-1:0] r_val [NNZ_MAX];

  logic             w_start_load;
  logic             w_start_keep;
  logic             w_start_bad;
  logic             w_in_hs;
  logic             w_bad_idx;
  logic             w_full;
  logic             w_store;
  logic             w_vec_hs;
  logic             w_out_hs;
  logic             w_r_last;
  logic             w_k_last;
  logic             w_acc_en;
  logic [IW-1:0]    w_kidx;
  logic [IW-1:0]    w_widx;
  logic [RW-1:0]    w_crow;
  logic [CW-1:0]    w_ccol;
  logic [VAL_W-1:0] w_cval;
  logic             w_hit;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_sat;

  assign w_start_load = (r_state == S_IDLE) && start && !keep_matrix;
  assign w_start_keep = (r_state == S_IDLE) && start && keep_matrix && r_mvalid;
  assign w_start_bad  = (r_state == S_IDLE) && start && keep_matrix && !r_mvalid;

  assign w_in_hs   = (r_state == S_LOAD) && in_valid;
  assign w_bad_idx = (32'(in_row) >= ROWS) || (32'(in_col) >= COLS);
  assign w_full    = (r_nnz == NW'(NNZ_MAX));
  assign w_store   = w_in_hs && !w_bad_idx && !w_full;
  assign w_widx    = r_nnz[IW-1:0];

  assign w_vec_hs = (r_state == S_WAIT_VEC) && vec_valid;
  assign w_out_hs = (r_state == S_DRAIN) && out_ready;
  assign w_r_last = (r_r == RW'(ROWS - 1));

  // An empty matrix still spends one cycle in COMPUTE but adds nothing.
  assign w_k_last = (r_nnz == '0) || ((r_k + NW'(1)) == r_nnz);
  assign w_acc_en = (r_state == S_COMPUTE) && (r_nnz != '0);

  assign w_kidx = r_k[IW-1:0];
  assign w_crow = r_row[w_kidx];
  assign w_ccol = r_col[w_kidx];
  assign w_cval = r_val[w_kidx];
  assign w_hit  = r_vec[w_ccol];

  // Carry out of the widened sum means the row total clips at full scale.
  assign w_sum = {1'b0, r_acc[w_crow]} + (w_hit ? (ACC_W+1)'(w_cval) : '0);
  assign w_sat = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_load) begin
          w_next = S_LOAD;
        end else if (w_start_keep) begin
          w_next = S_WAIT_VEC;
        end
      end
      S_LOAD: begin
        if (w_in_hs && in_last) begin
          w_next = S_WAIT_VEC;
        end
      end
      S_WAIT_VEC: begin
        if (w_vec_hs) begin
          w_next = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (w_k_last) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_hs && w_r_last) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nnz    <= '0;
      r_k      <= '0;
      r_r      <= '0;
      r_vec    <= '0;
      r_err    <= 1'b0;
      r_mvalid <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      if (w_start_load) begin
        r_nnz    <= '0;
        r_err    <= 1'b0;
        r_mvalid <= 1'b0;
      end
      if (w_start_keep) begin
        r_err <= 1'b0;
      end
      if (w_start_bad) begin
        r_err <= 1'b1;
      end
      if (w_in_hs) begin
        if (w_bad_idx || w_full) begin
          r_err <= 1'b1;
        end else begin
          r_nnz <= r_nnz + NW'(1);
        end
        if (in_last) begin
          r_mvalid <= 1'b1;
        end
      end
      if (w_vec_hs) begin
        r_vec <= vec_data;
        r_k   <= '0;
        r_r   <= '0;
        for (int i = 0; i < ROWS; i++) begin
          r_acc[i] <= '0;
        end
      end
      if (w_acc_en) begin
        r_acc[w_crow] <= w_sat;
        r_k           <= r_k + NW'(1);
      end
      if (w_out_hs) begin
        r_r <= w_r_last ? '0 : r_r + RW'(1);
      end
    end
  end

  // Entry storage needs no reset; it is only read below the valid count.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_row[w_widx] <= in_row;
      r_col[w_widx] <= in_col;
      r_val[w_widx] <= in_val;
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign vec_ready = (r_state == S_WAIT_VEC);
  assign out_valid = (r_state == S_DRAIN);
  assign out_data  = (r_state == S_DRAIN) ? r_acc[r_r] : '0;
  assign out_idx   = (r_state == S_DRAIN) ? r_r : '0;
  assign out_last  = (r_state == S_DRAIN) && w_r_last;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

endmodule

// File: tb/tb_csr_mvm_engine.sv
// Directed bench for csr_mvm_engine: load, reuse, saturation,
// overflow, backpressure and reset-abort scenarios.
module tb_csr_mvm_engine;

  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int NNZ_MAX = 16;
  localparam int VAL_W   = 8;
  localparam int ACC_W   = 10;
  localparam int RW      = 2;
  localparam int CW      = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             keep_matrix;
  logic             in_valid;
  logic             in_ready;
  logic [RW-1:0]    in_row;
  logic [CW-1:0]    in_col;
  logic [VAL_W-1:0] in_val;
  logic             in_last;
  logic             vec_valid;
  logic             vec_ready;
  logic [COLS-1:0]  vec_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [RW-1:0]    out_idx;
  logic             out_last;
  logic             busy;
  logic             err;

  int n_chk  = 0;
  int n_fail = 0;

  csr_mvm_engine #(
    .ROWS(ROWS), .COLS(COLS), .NNZ_MAX(NNZ_MAX),
    .VAL_W(VAL_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .keep_matrix(keep_matrix),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_col(in_col),
    .in_val(in_val), .in_last(in_last),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic keep);
    start       = 1'b1;
    keep_matrix = keep;
    tick();
    start       = 1'b0;
    keep_matrix = 1'b0;
  endtask

  task automatic beat(input int r, input int c,
                      input int v, input logic last);
    in_valid = 1'b1;
    in_row   = RW'(r);
    in_col   = CW'(c);
    in_val   = VAL_W'(v);
    in_last  = last;
    chk("in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [COLS-1:0] v,
                          input int nnz);
    int cyc;
    vec_valid = 1'b1;
    vec_data  = v;
    chk("vec_ready", 32'(vec_ready), 1);
    tick();
    vec_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(nnz + 1));
  endtask

  task automatic drain(input int e0, input int e1,
                       input int e2, input int e3,
                       input int bp_idx, input int bp_n);
    int e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      if (r == bp_idx) begin
        out_ready = 1'b0;
        for (int b = 0; b < bp_n; b++) begin
          chk("bp_valid", 32'(out_valid), 1);
          chk("bp_idx", 32'(out_idx), 32'(r));
          chk("bp_data", 32'(out_data), 32'(e[r]));
          chk("bp_last", 32'(out_last), 32'(r == 3));
          tick();
        end
        out_ready = 1'b1;
      end
      chk("out_valid", 32'(out_valid), 1);
      chk("out_idx", 32'(out_idx), 32'(r));
      chk("out_data", 32'(out_data), 32'(e[r]));
      chk("out_last", 32'(out_last), 32'(r == 3));
      tick();
    end
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    keep_matrix = 1'b0;
    in_valid    = 1'b0;
    in_row      = '0;
    in_col      = '0;
    in_val      = '0;
    in_last     = 1'b0;
    vec_valid   = 1'b0;
    vec_data    = '0;
    out_ready   = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_vec_ready", 32'(vec_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_out_data", 32'(out_data), 0);
    tick();
    tick();
    rst = 1'b0;

    // Basic MVM; start accepted on first edge after reset release
    start_op(1'b0);
    chk("load_busy", 32'(busy), 1);
    beat(0, 0, 5, 1'b0);
    beat(0, 2, 3, 1'b0);
    beat(1, 1, 7, 1'b0);
    beat(3, 3, 200, 1'b0);
    beat(3, 0, 100, 1'b1);
    chk("wv_in_ready", 32'(in_ready), 0);
    start_op(1'b0);
    chk("ign_start_vec_ready", 32'(vec_ready), 1);
    chk("ign_start_in_ready", 32'(in_ready), 0);
    send_vec(4'b1101, 5);
    drain(8, 0, 0, 300, -1, 0);
    chk("basic_err", 32'(err), 0);

    // Matrix reuse skips LOAD
    start_op(1'b1);
    chk("reuse_in_ready", 32'(in_ready), 0);
    chk("reuse_vec_ready", 32'(vec_ready), 1);
    send_vec(4'b0010, 5);
    drain(0, 7, 0, 0, -1, 0);

    // Backpressure at idx2 for 3 cycles, idx3 for 1
    start_op(1'b1);
    send_vec(4'b1111, 5);
    drain(8, 7, 0, 300, 2, 3);
    start_op(1'b1);
    send_vec(4'b1001, 5);
    drain(5, 0, 0, 300, 3, 1);

    // Saturation at 2^10-1
    start_op(1'b0);
    for (int i = 0; i < 5; i++) begin
      beat(0, 0, 255, i == 4);
    end
    chk("sat_err", 32'(err), 0);
    send_vec(4'b0001, 5);
    drain(1023, 0, 0, 0, -1, 0);

    // Capacity overflow: 18 beats, 16 kept
    start_op(1'b0);
    for (int i = 0; i < 18; i++) begin
      beat(1, 1, 1, i == 17);
    end
    chk("ovf_err", 32'(err), 1);
    send_vec(4'b0010, 16);
    drain(0, 16, 0, 0, -1, 0);
    chk("ovf_err_sticky", 32'(err), 1);

    // Reset during COMPUTE
    start_op(1'b1);
    chk("keep_clears_err", 32'(err), 0);
    vec_valid = 1'b1;
    vec_data  = 4'b1111;
    tick();
    vec_valid = 1'b0;
    tick();
    chk("cmp_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_out_idx", 32'(out_idx), 0);
    chk("arst_out_last", 32'(out_last), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_vec_ready", 32'(vec_ready), 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_no_beat", 32'(out_valid), 0);
    end
    out_ready = 1'b0;
    start_op(1'b1);
    chk("nomat_err", 32'(err), 1);
    chk("nomat_busy", 32'(busy), 0);
    chk("nomat_vec_ready", 32'(vec_ready), 0);
    tick();
    chk("nomat_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
